// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_arbiter                                              |
// | Purpose  : Round-robin arbiter that shares one APB completer between       |
// |            NUM_REQ local requesters, with ACCESS-phase timeout.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_SETUP    = 2'd1;
    localparam logic [1:0]       c_ACCESS   = 2'd2;
    localparam logic [PTR_W-1:0] c_PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [PTR_W-1:0]      r_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [PTR_W-1:0]      w_grant;
    logic                  w_any;
    logic                  w_cnt_last;
    logic                  w_launch;
    logic                  w_finish;
    logic [NUM_REQ-1:0]    w_ready_nxt;
    logic [NUM_REQ-1:0]    w_rspv_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_wdata_sel;
    logic                  w_write_sel;

    // r_ptr holds the last grant; it also names the requester of the transfer in flight.
    // Scan from farthest to nearest so the nearest valid requester after r_ptr wins.
    always_comb begin
        w_grant = r_ptr;
        w_any   = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[PTR_W'((int'(r_ptr) + i) % NUM_REQ)]) begin
                w_grant = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        w_addr_sel  = '0;
        w_wdata_sel = '0;
        w_write_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_addr_sel  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata_sel = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_write_sel = req_write[i];
            end
        end
    end

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_any) w_state_nxt = c_SETUP;
            c_SETUP:  w_state_nxt = c_ACCESS;
            c_ACCESS: if (PREADY || w_cnt_last) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        w_ready_nxt = '0;
        w_rspv_nxt  = '0;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_ready_nxt = NUM_REQ'(1) << w_grant;
                    w_launch    = 1'b1;
                end
            end
            c_ACCESS: begin
                if (PREADY || w_cnt_last) begin
                    w_rspv_nxt = NUM_REQ'(1) << r_ptr;
                    w_finish   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ptr     <= c_PTR_RST;
            r_cnt     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            req_ready <= w_ready_nxt;
            rsp_valid <= w_rspv_nxt;
            PSEL      <= (w_state_nxt != c_IDLE);
            PENABLE   <= (w_state_nxt == c_ACCESS);
            if (w_launch) begin
                r_ptr  <= w_grant;
                r_cnt  <= '0;
                PADDR  <= w_addr_sel;
                PWDATA <= w_wdata_sel;
                PWRITE <= w_write_sel;
            end
            if (r_state == c_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // PREADY on the final ACCESS cycle still counts as a successful completion.
            if (w_finish) begin
                rsp_err   <= !PREADY;
                rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_master_arbiter                                           |
// | Purpose  : Self-checking bench for apb_master_arbiter.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_apb_master_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [AW-1:0]    PADDR;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DW-1:0]    PWDATA;
    logic [DW-1:0]    PRDATA;
    logic             PREADY;

    apb_master_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          idx;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          rdy_on;     // ACCESS cycle on which PREADY rises; 0 = never
        logic [31:0] prdata;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic do_reset();
        PRESET    = 1'b1;
        req_valid = '0;
        PREADY    = 1'b0;
        step();
        step();
        check("reset req_ready", req_ready, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset PADDR", PADDR, 0);
        check("reset PSEL", PSEL, 0);
        check("reset PENABLE", PENABLE, 0);
        check("reset PWRITE", PWRITE, 0);
        check("reset PWDATA", PWDATA, 0);
        PRESET = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          n;
        logic [NR-1:0] oh;
        oh = NR'(1) << v.idx;
        req_valid = oh;
        req_write[v.idx] = v.wr;
        req_addr[v.idx*AW +: AW] = v.addr;
        req_wdata[v.idx*DW +: DW] = v.wdata;
        PREADY = 1'b0;
        step();
        check("vec setup req_ready", req_ready, oh);
        check("vec setup PSEL", PSEL, 1);
        check("vec setup PENABLE", PENABLE, 0);
        check("vec setup PADDR", PADDR, v.addr);
        check("vec setup PWRITE", PWRITE, v.wr);
        check("vec setup PWDATA", PWDATA, v.wdata);
        req_valid = '0;
        n = 0;
        step();
        while (PSEL && n < 40) begin
            n++;
            check("vec access PENABLE", PENABLE, 1);
            check("vec access PADDR", PADDR, v.addr);
            check("vec access req_ready", req_ready, 0);
            PREADY = (n == v.rdy_on);
            PRDATA = v.prdata;
            step();
        end
        PREADY = 1'b0;
        check("vec access cycles", n, v.exp_cyc);
        check("vec rsp_valid", rsp_valid, oh);
        check("vec rsp_rdata", rsp_rdata, v.exp_rdata);
        check("vec rsp_err", rsp_err, v.exp_err);
        check("vec end PENABLE", PENABLE, 0);
        step();
        check("vec rsp pulse width", rsp_valid, 0);
        check("vec rsp_rdata hold", rsp_rdata, v.exp_rdata);
        check("vec rsp_err hold", rsp_err, v.exp_err);
    endtask

    // Random-phase reference state
    logic [NR-1:0] pend;
    logic          f_wr[NR];
    logic [AW-1:0] f_addr[NR];
    logic [DW-1:0] f_wdata[NR];
    logic [NR-1:0] prev_valid;
    bit            prev_idle, acc_cont, stuck, rsp_due, x_wr, rsp_e;
    int            last, cur, done_idx, acc_n, phase, g;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, rsp_d;
    logic [NR-1:0] exp_ready;

    initial begin
        int grants[$];
        int last_t;

        vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 2,  32'h55555555, 2,  32'h0,        1'b0};
        vecs[1] = '{2, 1'b0, 8'h10, 32'h0,        1,  32'hDEADBEEF, 1,  32'hDEADBEEF, 1'b0};
        vecs[2] = '{1, 1'b0, 8'h44, 32'h0,        0,  32'hA5A5A5A5, 16, 32'h0,        1'b1};
        vecs[3] = '{3, 1'b0, 8'h7F, 32'h0,        16, 32'h12345678, 16, 32'h12345678, 1'b0};
        vecs[4] = '{1, 1'b1, 8'hC3, 32'h0BADF00D, 17, 32'hFFFFFFFF, 16, 32'h0,        1'b1};
        vecs[5] = '{3, 1'b1, 8'h01, 32'hCAFEF00D, 1,  32'h11111111, 1,  32'h0,        1'b0};

        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // All requesters held: strict rotation, one grant every three cycles.
        do_reset();
        req_write = '0;
        req_addr  = {8'h33, 8'h22, 8'h11, 8'h00};
        req_valid = '1;
        PREADY    = 1'b1;
        last_t    = -1;
        for (int c = 0; c < 16; c++) begin
            step();
            check("rr ready onehot", $countones(req_ready) <= 1, 1);
            check("rr rsp onehot", $countones(rsp_valid) <= 1, 1);
            if (req_ready != 0) begin
                for (int k = 0; k < NR; k++) if (req_ready[k]) grants.push_back(k);
                if (last_t >= 0) check("rr spacing", c - last_t, 3);
                last_t = c;
                check("rr PADDR", PADDR, 8'h11 * grants[grants.size()-1]);
            end
        end
        for (int i = 0; i < 5; i++)
            check($sformatf("rr grant %0d", i), (i < grants.size()) ? grants[i] : -1, i % NR);
        req_valid = '0;
        PREADY    = 1'b0;

        // Reset during an ACCESS of requester 3.
        do_reset();
        req_valid = 4'b1000;
        req_addr  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        step();
        check("abort setup ready", req_ready, 4'b1000);
        req_valid = '0;
        step();
        step();
        check("abort in access", PENABLE, 1);
        PRESET    = 1'b1;
        req_valid = 4'b1010;
        step();
        check("abort PSEL", PSEL, 0);
        check("abort PENABLE", PENABLE, 0);
        check("abort rsp_valid", rsp_valid, 0);
        PRESET = 1'b0;
        step();
        check("abort regrant req1", req_ready, 4'b0010);
        check("abort regrant PADDR", PADDR, 8'hA1);
        check("abort no late rsp", rsp_valid, 0);
        req_valid = '0;
        PREADY    = 1'b1;
        step();
        step();
        check("abort req1 rsp", rsp_valid, 4'b0010);
        PREADY = 1'b0;

        // Randomised traffic against a transaction-level reference.
        do_reset();
        pend = '0; prev_valid = '0; prev_idle = 1; acc_cont = 0; rsp_due = 0;
        last = NR - 1; cur = 0; done_idx = 0; acc_n = 0; stuck = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_ready = '0;
            g = -1;
            if (prev_idle && prev_valid != 0) begin
                g = pick(prev_valid, last);
                exp_ready = NR'(1) << g;
            end
            check("rnd req_ready", req_ready, exp_ready);
            check("rnd rsp_valid", rsp_valid, rsp_due ? (NR'(1) << done_idx) : NR'(0));
            if (rsp_due) begin
                check("rnd rsp_rdata", rsp_rdata, rsp_d);
                check("rnd rsp_err", rsp_err, rsp_e);
            end
            rsp_due = 0;
            if (g >= 0) begin
                phase   = 1;
                last    = g;
                cur     = g;
                pend[g] = 1'b0;
                x_wr    = f_wr[g];
                x_addr  = f_addr[g];
                x_wdata = f_wdata[g];
                acc_n   = 0;
                stuck   = ($urandom_range(0, 4) == 0);
            end else if (acc_cont) begin
                phase = 2;
            end else begin
                phase = 0;
            end
            check("rnd PSEL", PSEL, phase != 0);
            check("rnd PENABLE", PENABLE, phase == 2);
            if (phase != 0) begin
                check("rnd PADDR", PADDR, x_addr);
                check("rnd PWRITE", PWRITE, x_wr);
                check("rnd PWDATA", PWDATA, x_wdata);
            end
            acc_cont = (phase == 1);
            PREADY   = 1'($urandom_range(0, 1));
            PRDATA   = $urandom;
            if (phase == 2) begin
                acc_n++;
                PREADY = !stuck && ($urandom_range(0, 3) == 0);
                if (PREADY) begin
                    rsp_due = 1; rsp_d = x_wr ? '0 : PRDATA; rsp_e = 0; done_idx = cur;
                end else if (acc_n == TO) begin
                    rsp_due = 1; rsp_d = '0; rsp_e = 1; done_idx = cur;
                end else begin
                    acc_cont = 1;
                end
            end
            prev_idle = (phase == 0);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]    = 1'b1;
                    f_wr[i]    = 1'($urandom_range(0, 1));
                    f_addr[i]  = AW'($urandom);
                    f_wdata[i] = $urandom;
                end
                req_write[i]          = f_wr[i];
                req_addr[i*AW +: AW]  = f_addr[i];
                req_wdata[i*DW +: DW] = f_wdata[i];
            end
            req_valid  = pend;
            prev_valid = pend;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
